// File: rtl/serial_slave.sv
// Bit-serial bus slave with internal word memory; serial address, data in/out.
// Optional write-data timeout in WAIT_DATA enabled by SLAVE_TIMEOUT_EN.
module serial_slave #(
  parameter int N          = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic validIn,
  input  logic wren,
  input  logic Address,
  input  logic DataIn,
  output logic ready,
  output logic validOut,
  output logic DataOut
);

  localparam int M1   = (ADDR_WIDTH > N) ? ADDR_WIDTH : N;
  localparam int CMAX = (M1 > TIMEOUT) ? M1 : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, WAIT_DATA, RX_DATA, RD_MEM, TX_DATA
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_sr, addr_n;
  logic [N-1:0]          data_sr, data_n;
  logic [N-1:0]          tx_sr, tx_n, cur;
  logic [N-1:0]          rdata, wdata;
  logic                  wren_q, wren_n;
  logic                  valid_q, start, we;
  logic                  ready_n, vout_n, dout_n;

  logic [N-1:0] mem [2**ADDR_WIDTH];

  assign start = validIn & ~valid_q;
  assign wdata = {DataIn, data_sr[N-1:1]};

  // memory is never reset; rdata tracks the latched address
  always_ff @(posedge clk) begin
    if (we)
      mem[addr_sr] <= wdata;
    rdata <= mem[addr_sr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      tx_sr    <= '0;
      wren_q   <= 1'b0;
      valid_q  <= 1'b0;
      ready    <= 1'b0;
      validOut <= 1'b0;
      DataOut  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_sr  <= addr_n;
      data_sr  <= data_n;
      tx_sr    <= tx_n;
      wren_q   <= wren_n;
      valid_q  <= validIn;
      ready    <= ready_n;
      validOut <= vout_n;
      DataOut  <= dout_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_sr;
    data_n  = data_sr;
    tx_n    = tx_sr;
    wren_n  = wren_q;
    ready_n = 1'b0;
    vout_n  = 1'b0;
    dout_n  = 1'b0;
    we      = 1'b0;
    cur     = tx_sr;
    unique case (state)
      IDLE: begin
        if (start) begin
          wren_n  = wren;
          cnt_n   = '0;
          state_n = RX_ADDR;
        end
      end
      RX_ADDR: begin
        addr_n = {Address, addr_sr[ADDR_WIDTH-1:1]};
        if (cnt == CW'(ADDR_WIDTH - 1)) begin
          cnt_n = '0;
          if (wren_q) begin
            state_n = WAIT_DATA;
            ready_n = 1'b1;
          end else begin
            state_n = RD_MEM;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_DATA: begin
        ready_n = 1'b1;
        if (validIn) begin
          data_n  = wdata;
          cnt_n   = CW'(1);
          ready_n = 1'b0;
          state_n = RX_DATA;
        end
`ifdef SLAVE_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          ready_n = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
`endif
      end
      RX_DATA: begin
        data_n = wdata;
        if (cnt == CW'(N - 1)) begin
          we      = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RD_MEM: begin
        cnt_n   = '0;
        state_n = TX_DATA;
      end
      TX_DATA: begin
        // first bit comes straight from the memory register
        cur    = (cnt == '0) ? rdata : tx_sr;
        vout_n = 1'b1;
        dout_n = cur[0];
        tx_n   = cur >> 1;
        if (cnt == CW'(N - 1))
          state_n = IDLE;
        else
          cnt_n = cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_slave.sv
// Randomized self-checking bench for serial_slave against a word-memory model.
// Timeout behaviour is checked according to SLAVE_TIMEOUT_EN.
module tb_serial_slave;

  localparam int N  = 8;
  localparam int AW = 12;
  localparam int TO = 16;

  logic clk = 0;
  logic rst = 0;
  logic validIn = 0, wren = 0, Address = 0, DataIn = 0;
  logic ready, validOut, DataOut;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] model [int];

  serial_slave #(.N(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .wren(wren),
    .Address(Address), .DataIn(DataIn), .ready(ready),
    .validOut(validOut), .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    validIn = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // start edge plus all address bits; ends just after E_AW
  task automatic start_txn(logic wr, logic [AW-1:0] a);
    validIn = 1;
    wren = wr;
    tick();
    validIn = 0;
    wren = ~wr;
    for (int i = 0; i < AW; i++) begin
      Address = a[i];
      tick();
    end
    chk("ready_after_addr", ready, wr);
  endtask

  task automatic send_data(logic [AW-1:0] a, logic [N-1:0] d,
                           int gap, bit surplus);
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("ready_gap", ready, 1);
    end
    for (int i = 0; i < N; i++) begin
      validIn = 1;
      DataIn = d[i];
      tick();
      if (i == 0) chk("ready_fall", ready, 0);
    end
    if (surplus) begin
      DataIn = 1;
      tick();
    end
    validIn = 0;
    DataIn = 0;
    tick();
    model[int'(a)] = d;
  endtask

  task automatic write_word(logic [AW-1:0] a, logic [N-1:0] d,
                            int gap, bit surplus);
    start_txn(1, a);
    send_data(a, d, gap, surplus);
  endtask

  task automatic read_word(logic [AW-1:0] a);
    logic [N-1:0] got;
    got = '0;
    start_txn(0, a);
    tick();
    chk("vout_early", validOut, 0);
    for (int i = 0; i < N; i++) begin
      tick();
      chk("vout_high", validOut, 1);
      got[i] = DataOut;
    end
    tick();
    chk("vout_end", {validOut, DataOut}, 0);
    if (model.exists(int'(a)))
      chk("read_data", got, model[int'(a)]);
  endtask

  initial begin
    logic [AW-1:0] pool [4];
    logic [AW-1:0] a;
    rst = 1;
    tick();
    chk("reset_outs", {ready, validOut, DataOut}, 0);
    rst = 0;
    idle(2);

    // reset in the middle of an address
    validIn = 1;
    wren = 1;
    tick();
    validIn = 0;
    for (int i = 0; i < 5; i++) begin
      Address = 1;
      tick();
    end
    rst = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_mid_addr", {ready, validOut, DataOut}, 0);
    rst = 0;
    idle(1);

    write_word(12'h964, 8'h4E, 0, 0);
    chk("ready_idle", ready, 0);
    idle(1);
    read_word(12'h964);
    idle(1);

    // surplus bit with validIn held must not start a new transaction
    write_word(12'h964, 8'h4E, 2, 1);
    chk("no_restart", ready, 0);
    idle(2);
    read_word(12'h964);
    idle(1);

    // partial write aborted by reset is not committed
    start_txn(1, 12'h964);
    for (int i = 0; i < 4; i++) begin
      validIn = 1;
      DataIn = 1;
      tick();
    end
    rst = 1;
    validIn = 0;
    tick();
    tick();
    rst = 0;
    idle(1);
    read_word(12'h964);
    idle(1);

    // write elsewhere, then read an unwritten address
    write_word(12'h0A5, 8'hC3, 1, 0);
    idle(1);
    read_word(12'h123);
    idle(1);
    read_word(12'h0A5);
    idle(1);

    // write-data wait limit
    start_txn(1, 12'h964);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("ready_before_to", ready, 1);
    tick();
`ifdef SLAVE_TIMEOUT_EN
    chk("ready_timeout", ready, 0);
    idle(2);
`else
    chk("ready_no_timeout", ready, 1);
    send_data(12'h964, 8'h5A, 0, 0);
    idle(1);
`endif
    read_word(12'h964);
    idle(1);

    for (int i = 0; i < 4; i++) pool[i] = AW'($urandom);
    for (int k = 0; k < 24; k++) begin
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1 || !model.exists(int'(a)))
        write_word(a, N'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
      else
        read_word(a);
      idle($urandom_range(1, 3));
    end
    for (int i = 0; i < 4; i++) begin
      read_word(pool[i]);
      idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_slave.md
# serial_slave

Bit-serial bus slave containing an internal word-addressed memory. It sits on the serial system bus behind the master/arbiter and receives a start strobe, a read/write flag and a bit-serial address. Writes then receive bit-serial data into memory after a `ready` handshake; reads return the stored word bit-serially with a `validOut` qualifier.

## Interface
- `N`, default 8: data word width in bits.
- `ADDR_WIDTH`, default 12: serial address length in bits; memory depth is 2^ADDR_WIDTH words of `N` bits.
- `TIMEOUT`, default 16: write-data wait limit in cycles (used only with `SLAVE_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `validIn`  in  1  transaction start strobe (rising edge) and write-data qualifier.
- `wren`  in  1  1 = write, 0 = read; sampled with the start strobe.
- `Address`  in  1  serial address bit, LSB first.
- `DataIn`  in  1  serial write data bit, LSB first.
- `ready`  out  1  high while the slave waits for write data.
- `validOut`  out  1  high while `DataOut` carries read data.
- `DataOut`  out  1  serial read data bit, LSB first.

## Operation
- A transaction starts on a rising edge of `validIn`: `validIn`=1 at a clock edge and 0 at the previous edge (one register, reset 0). A level held high never restarts a transaction.
- States: IDLE, RX_ADDR, WAIT_DATA, RX_DATA, RD_MEM, TX_DATA.
- IDLE: on a start, latch `wren` and go to RX_ADDR.
- RX_ADDR: sample `Address` on each of the next `ADDR_WIDTH` edges, bit 0 first. `validIn` and `wren` are ignored here.
  - After the last bit, go to WAIT_DATA if the latched `wren`=1, otherwise go to RD_MEM.
- WAIT_DATA: `ready`=1. At the first edge with `validIn`=1, capture `DataIn` as data bit 0 and go to RX_DATA.
- RX_DATA: capture the next N-1 bits, one per edge, regardless of `validIn`.
  - At the edge capturing bit N-1, write the assembled word to mem[addr] and return to IDLE.
  - Surplus bits while `validIn` stays high are ignored.
- RD_MEM: one cycle for the synchronous memory read, then go to TX_DATA.
- TX_DATA: for N cycles `validOut`=1 and `DataOut`=word[i], i = 0..N-1. Then return to IDLE with `validOut`=0 and `DataOut`=0.
- All outputs are registered.

## Timing
- Reset values: `ready`=0, `validOut`=0, `DataOut`=0, state IDLE, shift registers 0.
- Reset mid-transaction aborts to IDLE. Memory contents are never cleared by reset. Partial writes are not committed.
- With the start seen at edge E0:
  - Address bits are sampled at E1..E_ADDR_WIDTH.
  - `ready` rises after edge E_ADDR_WIDTH.
- Write: the first data bit is sampled at the first edge with `validIn`=1 while `ready`=1. `ready` falls after that edge. The memory write happens at the edge of the Nth bit.
- Read: `validOut` rises after edge E_ADDR_WIDTH+2 and stays high exactly N cycles.
- A write followed by a read of the same address returns the new data, provided the read starts at least one cycle after the commit.
- A start occurring in any state other than IDLE is ignored.

## Configuration
- `SLAVE_TIMEOUT_EN` defined: if WAIT_DATA sees no `validIn` within `TIMEOUT` cycles, `ready` drops, nothing is written and the state returns to IDLE.
- `SLAVE_TIMEOUT_EN` undefined: WAIT_DATA waits indefinitely.

## Test plan
- Reset: assert `rst` for 3 cycles mid-address -> `ready`=0, `validOut`=0, `DataOut`=0, next start is accepted normally.
- Write: start with `wren`=1, address bits 0,0,1,0,0,1,1,0,1,0,0,1 (0x964) -> `ready`=1. Then `validIn`=1 with data bits 0,1,1,1,0,0,1,0 -> mem[0x964]=0x4E, `ready`=0.
- Surplus bit: same write with a 9th bit (1) while `validIn` is held high -> no new transaction, mem[0x964] stays 0x4E.
- Read: start with `wren`=0, address 0x964 -> `validOut` high for 8 cycles, 2 edges after the last address bit, `DataOut` sequence 0,1,1,1,0,0,1,0.
- Read of an unwritten address after a prior write to a different address -> contents unaffected by that write, `validOut` width exactly 8.
- With `SLAVE_TIMEOUT_EN`: write address, hold `validIn`=0 for 16 cycles -> `ready` drops, IDLE, memory unchanged. Without it: `ready` stays high.
